// File: rtl/tmr_ctrl_pkg.sv
// Shared types and helpers for the TMR scrub/monitor blocks.
package tmr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        SCRUB  = 2'd2,
        SETTLE = 2'd3
    } state_e;

    // Width of an index into n items; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tmr_prio_enc.sv
// Lowest-index priority encoder: reports the first set request bit.
module tmr_prio_enc #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan upward; the first set bit wins and later bits are ignored.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !any) begin
                idx = IW'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// Scrub scheduler and mismatch reporter for a bank of TMR registers.
module tmr_scrub_ctrl
    import tmr_ctrl_pkg::*;
#(
    parameter int unsigned NVOTERS      = 4,
    parameter int unsigned SCRUB_PERIOD = 16,
    parameter int unsigned SCRUB_LEN    = 2,
    parameter int unsigned CNT_W        = 8,
    localparam int unsigned VW          = idx_w(NVOTERS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               force_scrub,
    input  logic [NVOTERS-1:0] mismatch,
    input  logic               err_ready,
    input  logic               err_clear,
    output logic               scrub_en,
    output logic               scrub_busy,
    output logic               err_valid,
    output logic [VW-1:0]      err_voter,
    output logic [CNT_W-1:0]   err_count,
    output logic               err_lost
);

    localparam int unsigned TW = idx_w(SCRUB_PERIOD);
    localparam int unsigned SW = idx_w(SCRUB_LEN);
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(SCRUB_PERIOD - 1);
    localparam logic [SW-1:0] SCNT_RELOAD  = SW'(SCRUB_LEN - 1);

    state_e             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [SW-1:0]      scnt_q, scnt_d;
    logic               scrub_en_q, scrub_en_d;
    logic               scrub_busy_q, scrub_busy_d;
    logic               err_valid_q, err_valid_d;
    logic [VW-1:0]      err_voter_q, err_voter_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic               err_lost_q, err_lost_d;

    logic [VW-1:0]      low_idx;
    logic               any_mis;
    logic               err_hit;

    tmr_prio_enc #(
        .N  (NVOTERS),
        .IW (VW)
    ) u_prio (
        .req (mismatch),
        .idx (low_idx),
        .any (any_mis)
    );

    // Mismatches are ignored while replicas are being rewritten.
    assign err_hit = any_mis && !scrub_busy_q;

    // Next-state logic for the scrub scheduler.
    // Strobe outputs are decoded from the next state so they leave the flops aligned with state.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        scnt_d  = scnt_q;
        unique case (state_q)
            IDLE: begin
                if (force_scrub) begin
                    state_d = SCRUB;
                    scnt_d  = SCNT_RELOAD;
                end else if (enable) begin
                    state_d = COUNT;
                    timer_d = TIMER_RELOAD;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (force_scrub || timer_q == '0) begin
                    state_d = SCRUB;
                    scnt_d  = SCNT_RELOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            SCRUB: begin
                if (scnt_q == '0) begin
                    state_d = SETTLE;
                end else begin
                    scnt_d = scnt_q - 1'b1;
                end
            end
            SETTLE: begin
                if (enable) begin
                    state_d = COUNT;
                    timer_d = TIMER_RELOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        scrub_en_d   = (state_d == SCRUB);
        scrub_busy_d = (state_d == SCRUB) || (state_d == SETTLE);
    end

    // Next-state logic for the error counter and the first-error report.
    always_comb begin
        err_valid_d = err_valid_q;
        err_voter_d = err_voter_q;
        err_lost_d  = err_lost_q;
        err_count_d = err_count_q;
        if (err_hit && (!err_valid_q || err_ready)) begin
            err_valid_d = 1'b1;
            err_voter_d = low_idx;
        end else if (err_hit) begin
            err_lost_d = 1'b1;
        end else if (err_valid_q && err_ready) begin
            err_valid_d = 1'b0;
        end
        if (err_clear) begin
            err_count_d = '0;
            err_lost_d  = 1'b0;
        end else if (err_hit && err_count_q != '1) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    // All state and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            scnt_q       <= '0;
            scrub_en_q   <= 1'b0;
            scrub_busy_q <= 1'b0;
            err_valid_q  <= 1'b0;
            err_voter_q  <= '0;
            err_count_q  <= '0;
            err_lost_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            scnt_q       <= scnt_d;
            scrub_en_q   <= scrub_en_d;
            scrub_busy_q <= scrub_busy_d;
            err_valid_q  <= err_valid_d;
            err_voter_q  <= err_voter_d;
            err_count_q  <= err_count_d;
            err_lost_q   <= err_lost_d;
        end
    end

    assign scrub_en   = scrub_en_q;
    assign scrub_busy = scrub_busy_q;
    assign err_valid  = err_valid_q;
    assign err_voter  = err_voter_q;
    assign err_count  = err_count_q;
    assign err_lost   = err_lost_q;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Randomised bench for tmr_scrub_ctrl with a cycle-time reference model.
module tb_tmr_scrub_ctrl;

    localparam int NV   = 4;
    localparam int PER  = 16;
    localparam int LEN  = 2;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          force_scrub = 1'b0;
    logic [NV-1:0] mismatch = '0;
    logic          err_ready = 1'b0;
    logic          err_clear = 1'b0;
    logic          scrub_en;
    logic          scrub_busy;
    logic          err_valid;
    logic [1:0]    err_voter;
    logic [CW-1:0] err_count;
    logic          err_lost;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit check_en = 1'b0;

    // Model: mode 0 idle, 1 waiting for a scrub at m_deadline, 2 scrub window starting at m_start.
    int m_mode = 0;
    int m_deadline = 0;
    int m_start = 0;
    bit m_valid = 0;
    int m_voter = 0;
    int m_count = 0;
    bit m_lost = 0;

    tmr_scrub_ctrl #(
        .NVOTERS      (NV),
        .SCRUB_PERIOD (PER),
        .SCRUB_LEN    (LEN),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .force_scrub (force_scrub),
        .mismatch    (mismatch),
        .err_ready   (err_ready),
        .err_clear   (err_clear),
        .scrub_en    (scrub_en),
        .scrub_busy  (scrub_busy),
        .err_valid   (err_valid),
        .err_voter   (err_voter),
        .err_count   (err_count),
        .err_lost    (err_lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Advance the model over the cycle that ends at this edge, then count the cycle.
    always @(posedge clk) begin
        int  low;
        bit  hit;
        int  c;
        c = cyc;
        if (rst) begin
            m_mode  = 0;
            m_valid = 0;
            m_voter = 0;
            m_count = 0;
            m_lost  = 0;
        end else begin
            hit = (mismatch != 0) && (m_mode != 2);
            low = 0;
            for (int i = NV - 1; i >= 0; i--) if (mismatch[i]) low = i;
            if (hit && (!m_valid || err_ready)) begin
                m_valid = 1;
                m_voter = low;
            end else if (hit) begin
                m_lost = 1;
            end else if (m_valid && err_ready) begin
                m_valid = 0;
            end
            if (err_clear) begin
                m_count = 0;
                m_lost  = 0;
            end else if (hit && m_count < CMAX) begin
                m_count++;
            end
            case (m_mode)
                0: begin
                    if (force_scrub) begin
                        m_mode = 2; m_start = c + 1;
                    end else if (enable) begin
                        m_mode = 1; m_deadline = c + 1 + PER;
                    end
                end
                1: begin
                    if (!enable) m_mode = 0;
                    else if (force_scrub || c + 1 == m_deadline) begin
                        m_mode = 2; m_start = c + 1;
                    end
                end
                default: begin
                    if (c == m_start + LEN) begin
                        if (enable) begin
                            m_mode = 1; m_deadline = c + 1 + PER;
                        end else begin
                            m_mode = 0;
                        end
                    end
                end
            endcase
        end
        cyc++;
    end

    // Every cycle, compare all outputs with the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("scrub_en", int'(scrub_en), int'(m_mode == 2 && cyc < m_start + LEN));
            chk("scrub_busy", int'(scrub_busy), int'(m_mode == 2));
            chk("err_valid", int'(err_valid), int'(m_valid));
            chk("err_voter", int'(err_voter), m_voter);
            chk("err_count", int'(err_count), m_count);
            chk("err_lost", int'(err_lost), int'(m_lost));
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_rise(input int limit, output int at);
        bit prev;
        prev = scrub_en;
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (scrub_en && !prev) begin
                at = cyc;
                break;
            end
            prev = scrub_en;
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL scrub_rise_timeout at cycle %0d: no scrub_en rise within %0d cycles", cyc, limit);
        end
    endtask

    initial begin
        int t0;
        int r1;
        int n_en;

        // Reset
        step(3);
        rst = 1'b0;
        check_en = 1'b1;
        chk("reset_scrub_en", int'(scrub_en), 0);
        chk("reset_busy", int'(scrub_busy), 0);
        chk("reset_count", int'(err_count), 0);

        // Periodic scrubbing from enable
        t0 = cyc;
        enable = 1'b1;
        wait_rise(40, r1);
        chk("first_rise", r1 - t0, PER + 1);
        step(2);
        chk("settle_busy", int'(scrub_busy), 1);
        chk("settle_scrub_en", int'(scrub_en), 0);
        wait_rise(40, r1);
        chk("second_rise", r1 - t0, 36);
        enable = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;

        // Forced scrub with enable low
        step(5);
        force_scrub = 1'b1;
        step(1);
        force_scrub = 1'b0;
        chk("force_scrub_en", int'(scrub_en), 1);
        n_en = 1;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (scrub_en) n_en++;
        end
        chk("force_scrub_cycles", n_en, LEN);

        // Single report held under back-pressure
        mismatch = 4'b1010;
        step(1);
        mismatch = '0;
        chk("rep_valid", int'(err_valid), 1);
        chk("rep_voter", int'(err_voter), 1);
        chk("rep_count", int'(err_count), 1);
        step(5);
        chk("rep_held_voter", int'(err_voter), 1);
        err_ready = 1'b1;
        step(1);
        err_ready = 1'b0;
        chk("rep_drained", int'(err_valid), 0);

        // Saturation and clear
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        mismatch = 4'b0001;
        step(300);
        mismatch = '0;
        step(1);
        chk("sat_count", int'(err_count), CMAX);
        chk("sat_lost", int'(err_lost), 1);
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        chk("clr_count", int'(err_count), 0);
        chk("clr_lost", int'(err_lost), 0);
        chk("clr_keeps_valid", int'(err_valid), 1);

        // Reset in the second scrub cycle
        enable = 1'b1;
        wait_rise(40, r1);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_scrub_en", int'(scrub_en), 0);
        chk("midrst_busy", int'(scrub_busy), 0);
        chk("midrst_valid", int'(err_valid), 0);
        t0 = cyc;
        wait_rise(40, r1);
        chk("midrst_rise", r1 - t0, 17);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            enable      = ($urandom_range(0, 9) != 0);
            force_scrub = ($urandom_range(0, 19) == 0);
            mismatch    = ($urandom_range(0, 3) == 0) ? NV'($urandom) : '0;
            err_ready   = $urandom_range(0, 1) != 0;
            err_clear   = ($urandom_range(0, 49) == 0);
            rst         = ($urandom_range(0, 199) == 0);
            step(1);
        end
        rst = 1'b0;
        enable = 1'b0;
        step(2);
        check_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
